dac_serializer: RTL and testbench
=================================

Name: dac_serializer

Overview:
- Downstream consumer of the 4-way source-select mux in the audio path.
- Takes the mux's selected parallel sample (e bus) and streams it to an external serial audio DAC in left-justified format.
- Generates the bit clock (sclk) and word clock (lrck) continuously and duplicates each mono sample onto both channels.
- Provides a one-entry holding buffer with a valid/ready handshake and flags underruns.

Parameters:
- REGBITS, 16, sample width in bits; must match the mux REGBITS; must be at least 2.
- CLKDIV, 4, clk cycles per sclk half-period; must be at least 1.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- sample  input  REGBITS  parallel sample from the mux output
- sample_valid  input  1  sample is valid this cycle
- ready  output  1  holding buffer empty; sample is accepted when sample_valid && ready
- sclk  output  1  DAC bit clock
- lrck  output  1  word clock; 0 = left, 1 = right
- sdata  output  1  serial data, MSB first
- underrun  output  1  one-clk pulse at a frame start when the buffer is empty

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high. All outputs are registered.
- Reset values:
  - sclk=0, lrck=0, sdata=0, ready=1, underrun=0.
  - Divider count=0, holding buffer empty, frame register=0.
  - Bit counter=2*REGBITS-1, so the first sclk falling edge is a frame start.
- Divider: counts 0..CLKDIV-1 and toggles sclk at the terminal count. The sclk period is 2*CLKDIV clk.
  - The first rising edge occurs CLKDIV clk after reset release; the first falling edge occurs 2*CLKDIV clk after.
- Data timing: sdata and lrck change only on the clk cycle where sclk goes 1->0. The DAC samples on the rising edge.
- Bit counter: advances on each sclk falling edge and wraps 2*REGBITS-1 -> 0.
  - Bit 0 is the frame start.
  - lrck=0 for bits 0..REGBITS-1 and lrck=1 for bits REGBITS..2*REGBITS-1.
  - sdata = frame_reg[REGBITS-1-(bit mod REGBITS)], so both halves carry the same sample, MSB first.
  - One frame is 4*REGBITS*CLKDIV clk (256 clk at the defaults).
- Frame start:
  - If the buffer is full: frame_reg loads the buffer, the buffer empties, and ready rises on the next clk.
  - If the buffer is empty: frame_reg keeps its last value (repeat) and underrun pulses high for exactly that clk.
- Handshake:
  - When ready=1 and sample_valid=1, the buffer captures sample and ready drops the next clk.
  - sample_valid while ready=0 is ignored; upstream must hold the sample.
- Simultaneous events:
  - If the buffer is empty and a write coincides with a frame start, that frame still underruns. The written sample is kept and plays at the next frame start.
  - If the buffer is full and valid coincides with a frame start, the write is not accepted because ready was 0 that cycle.
- Reset mid-frame: all state returns to the reset values on the next edge. The buffer contents and the frame in progress are discarded; there is no partial-frame completion.

Optional Feature:
- DAC_UNDERRUN_MUTE_EN defined: on underrun, frame_reg loads all zeros instead of repeating the last sample (mute).
- Not defined: the last sample repeats. The underrun pulse behaves identically in both builds.

Decomposition:
- Shared package audio_pkg holds:
  - the default sample width (16), shared with mux4 instances;
  - the frame-length constant 2*REGBITS;
  - the lrck channel encodings LEFT=0 and RIGHT=1.
- One natural sub-module: sclk_gen. It contains the divider and the sclk toggle, and outputs single-clk fall/rise strobes.
- The buffer, bit counter and shifter stay in dac_serializer.

Test Plan (REGBITS=16, CLKDIV=4):
- Reset held 3 clk, then released with no input -> sclk=lrck=sdata=0, ready=1. First sclk rise at clk 4, first fall at clk 8; underrun pulses at clk 8.
- Write 16'hA5C3 for one cycle while ready=1 -> ready=0 next clk. At the next frame start, sdata shifts 1010_0101_1100_0011 with lrck=0, then the same 16 bits with lrck=1. ready=1 one clk after the frame start.
- Write 16'h1234 then hold valid with 16'h5678 -> 16'h5678 is accepted only after the frame start that loads 16'h1234. Frames play 1234 then 5678 in order.
- After 16'hA5C3 plays, send no further samples -> next frame repeats A5C3 and underrun pulses once per frame. With DAC_UNDERRUN_MUTE_EN defined, the frame is all zeros.
- Assert reset during bit 7 of a frame with the buffer full -> all outputs take reset values the next clk, ready=1, and the old buffered sample is never output.
- Buffer empty, valid with 16'h00FF on exactly the frame-start clk -> that frame underruns (repeat/mute). 16'h00FF plays in the following frame.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared audio-path constants: default sample width, frame length and lrck channel codes.
package audio_pkg;

  localparam int unsigned AUDIO_REGBITS = 16;

  typedef enum logic {
    LEFT  = 1'b0,
    RIGHT = 1'b1
  } lrck_e;

  // A left-justified frame carries the sample once per channel.
  function automatic int unsigned frame_bits(input int unsigned regbits);
    return 2 * regbits;
  endfunction

  localparam int unsigned AUDIO_FRAME_BITS = frame_bits(AUDIO_REGBITS);

endpackage

// File: rtl/dac_serializer_sclk_gen.sv
// DAC bit-clock generator: divides clk by 2*CLKDIV and flags the clk cycle of each sclk edge.
module sclk_gen
  import audio_pkg::*;
#(
  parameter int unsigned CLKDIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic sclk,
  output logic fall_c,
  output logic rise_c
);

  localparam int unsigned DW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;

  logic [DW-1:0] div_q, div_d;
  logic          sclk_q, sclk_d;
  logic          tc_c;

  always_comb begin
    tc_c   = (div_q == DW'(CLKDIV - 1));
    div_d  = tc_c ? '0 : div_q + DW'(1);
    sclk_d = tc_c ? ~sclk_q : sclk_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      sclk_q <= sclk_d;
    end
  end

  // Strobes mark the clk cycle whose closing edge moves sclk.
  assign sclk   = sclk_q;
  assign fall_c = tc_c & sclk_q;
  assign rise_c = tc_c & ~sclk_q;

endmodule

// File: rtl/dac_serializer.sv
// Left-justified serial DAC feeder with one-entry holding buffer and underrun flag.
// Build option DAC_UNDERRUN_MUTE_EN: an underrun frame plays zeros instead of repeating.
module dac_serializer
  import audio_pkg::*;
#(
  parameter int unsigned REGBITS = AUDIO_REGBITS,
  parameter int unsigned CLKDIV  = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [REGBITS-1:0] sample,
  input  logic               sample_valid,
  output logic               ready,
  output logic               sclk,
  output logic               lrck,
  output logic               sdata,
  output logic               underrun
);

  localparam int unsigned FRAME_BITS = frame_bits(REGBITS);
  localparam int unsigned CW         = $clog2(FRAME_BITS);

  logic               sclk_fall;
  logic               sclk_rise_unused;

  logic               ready_q, ready_d;
  logic [REGBITS-1:0] buf_q, buf_d;
  logic [REGBITS-1:0] frame_q, frame_d;
  logic [REGBITS-1:0] shift_q, shift_d;
  logic [CW-1:0]      bit_q, bit_d;
  logic               lrck_q, lrck_d;
  logic               sdata_q, sdata_d;
  logic               underrun_q, underrun_d;

  sclk_gen #(
    .CLKDIV(CLKDIV)
  ) u_sclk_gen (
    .clk   (clk),
    .reset (reset),
    .sclk  (sclk),
    .fall_c(sclk_fall),
    .rise_c(sclk_rise_unused)
  );

  always_comb begin
    ready_d    = ready_q;
    buf_d      = buf_q;
    frame_d    = frame_q;
    shift_d    = shift_q;
    bit_d      = bit_q;
    lrck_d     = lrck_q;
    sdata_d    = sdata_q;
    underrun_d = 1'b0;

    // All serial outputs move only with the sclk falling edge.
    if (sclk_fall) begin
      bit_d = (bit_q == CW'(FRAME_BITS - 1)) ? '0 : bit_q + CW'(1);
      if (bit_d == '0) begin
        if (!ready_q) begin
          frame_d = buf_q;
          ready_d = 1'b1;
        end else begin
          underrun_d = 1'b1;
`ifdef DAC_UNDERRUN_MUTE_EN
          frame_d = '0;
`endif
        end
      end
      lrck_d = (bit_d >= CW'(REGBITS)) ? 1'(RIGHT) : 1'(LEFT);
      if ((bit_d == '0) || (bit_d == CW'(REGBITS))) begin
        sdata_d = frame_d[REGBITS-1];
        shift_d = frame_d << 1;
      end else begin
        sdata_d = shift_q[REGBITS-1];
        shift_d = shift_q << 1;
      end
    end

    // ready_q is the pre-edge view, so a write on a full-buffer frame start is refused.
    if (sample_valid && ready_q) begin
      buf_d   = sample;
      ready_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ready_q    <= 1'b1;
      buf_q      <= '0;
      frame_q    <= '0;
      shift_q    <= '0;
      bit_q      <= CW'(FRAME_BITS - 1);
      lrck_q     <= 1'(LEFT);
      sdata_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      ready_q    <= ready_d;
      buf_q      <= buf_d;
      frame_q    <= frame_d;
      shift_q    <= shift_d;
      bit_q      <= bit_d;
      lrck_q     <= lrck_d;
      sdata_q    <= sdata_d;
      underrun_q <= underrun_d;
    end
  end

  assign ready    = ready_q;
  assign lrck     = lrck_q;
  assign sdata    = sdata_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_dac_serializer.sv
// Self-checking bench for dac_serializer: cycle-timed reference plus a played-sample scoreboard.
module tb_dac_serializer;

  localparam int unsigned REGBITS = 16;
  localparam int unsigned CLKDIV  = 4;
  localparam int unsigned FB      = 2 * REGBITS;
  localparam int unsigned SP      = 2 * CLKDIV;
  localparam int unsigned BOUND   = 3000;

  logic               clk = 1'b0;
  logic               reset;
  logic [REGBITS-1:0] sample;
  logic               sample_valid;
  logic               ready, sclk, lrck, sdata, underrun;

  always #5 clk = ~clk;

  dac_serializer #(
    .REGBITS(REGBITS),
    .CLKDIV (CLKDIV)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sample      (sample),
    .sample_valid(sample_valid),
    .ready       (ready),
    .sclk        (sclk),
    .lrck        (lrck),
    .sdata       (sdata),
    .underrun    (underrun)
  );

  int unsigned tests = 0;
  int unsigned fails = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string tag);
    tests++;
    fails++;
    $display("FAIL %s: wait bound of %0d cycles expired", tag, BOUND);
  endtask

  // Reference: timing from cycles since reset release, buffer as a simple full/empty slot.
  int unsigned        m_t = 0;
  logic               m_seen = 1'b0;
  logic               m_empty = 1'b1;
  logic               m_under = 1'b0;
  logic               m_fresh = 1'b0;
  logic               m_acc = 1'b0;
  logic [REGBITS-1:0] m_buf = '0;
  logic [REGBITS-1:0] m_frame = '0;
  logic [REGBITS-1:0] sb_q[$];

  always @(posedge clk) begin
    logic acc;
    m_seen = 1'b1;
    if (reset) begin
      m_t = 0; m_empty = 1'b1; m_frame = '0; m_under = 1'b0;
      m_fresh = 1'b0; m_acc = 1'b0; sb_q.delete();
    end else begin
      acc     = sample_valid && m_empty;
      m_t++;
      m_under = 1'b0;
      if ((m_t % SP == 0) && (((m_t / SP) - 1) % FB == 0)) begin
        if (!m_empty) begin
          m_frame = m_buf; m_empty = 1'b1; m_fresh = 1'b1;
        end else begin
          m_under = 1'b1; m_fresh = 1'b0;
`ifdef DAC_UNDERRUN_MUTE_EN
          m_frame = '0;
`endif
        end
      end
      if (acc) begin
        m_buf = sample; m_empty = 1'b0; sb_q.push_back(sample);
      end
      m_acc = acc;
    end
  end

  function automatic int unsigned cur_bit();
    return ((m_t / SP) - 1) % FB;
  endfunction

  // Per-cycle output checks and frame collection on sclk rising edges.
  logic [FB-1:0]      word;
  logic               col_ok = 1'b0;
  always @(negedge clk) begin
    logic               e_lrck, e_sdata;
    int unsigned        b;
    logic [REGBITS-1:0] exp_w;
    if (reset) col_ok = 1'b0;
    if (m_seen) begin
      if (m_t < SP) begin
        e_lrck = 1'b0; e_sdata = 1'b0;
      end else begin
        b       = cur_bit();
        e_lrck  = (b >= REGBITS);
        e_sdata = m_frame[REGBITS-1-(b % REGBITS)];
      end
      check_eq("sclk", 32'(sclk), 32'((m_t / CLKDIV) % 2));
      check_eq("lrck", 32'(lrck), 32'(e_lrck));
      check_eq("sdata", 32'(sdata), 32'(e_sdata));
      check_eq("ready", 32'(ready), 32'(m_empty));
      check_eq("underrun", 32'(underrun), 32'(m_under));
      if (!reset && (m_t >= SP) && (m_t % SP == CLKDIV)) begin
        b = cur_bit();
        if (b == 0) begin
          col_ok = 1'b1; word = '0;
        end
        word[FB-1-b] = sdata;
        if ((b == FB - 1) && col_ok) begin
          exp_w = m_frame;
          if (m_fresh) begin
            check_eq("sb_has_entry", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) exp_w = sb_q.pop_front();
          end
          check_eq("frame_left", 32'(word[FB-1:REGBITS]), 32'(exp_w));
          check_eq("frame_right", 32'(word[REGBITS-1:0]), 32'(exp_w));
          col_ok = 1'b0;
        end
      end
    end
  end

  task automatic write_sample(input logic [REGBITS-1:0] s);
    int unsigned n = 0;
    sample = s;
    sample_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!m_acc && n < BOUND);
    if (!m_acc) timeout_fail("write_accept");
    sample_valid = 1'b0;
  endtask

  task automatic wait_empty();
    int unsigned n = 0;
    while (!m_empty && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    if (!m_empty) timeout_fail("buffer_drain");
  endtask

  task automatic wait_bit(input int unsigned target);
    int unsigned n = 0;
    while (!((m_t >= SP) && (cur_bit() == target)) && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    if (n >= BOUND) timeout_fail("wait_bit");
  endtask

  initial begin
    reset = 1'b1;
    sample_valid = 1'b0;
    sample = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Idle start: first frame underruns, zeros play.
    repeat (12) @(negedge clk);
    write_sample(16'hA5C3);
    check_eq("ready_drop", 32'(ready), 32'd0);
    repeat (600) @(negedge clk);

    // Back-to-back: second sample waits for the first frame start.
    write_sample(16'h1234);
    write_sample(16'h5678);
    repeat (4 * 256) @(negedge clk);

    // Reset during bit 7 with a full buffer discards both samples.
    write_sample(16'h1111);
    wait_empty();
    write_sample(16'h2222);
    wait_bit(7);
    reset = 1'b1;
    @(negedge clk);
    check_eq("rst_ready", 32'(ready), 32'd1);
    check_eq("rst_sclk", 32'(sclk), 32'd0);
    reset = 1'b0;

    // Write landing exactly on the frame-start clk still underruns that frame.
    repeat (7) @(negedge clk);
    sample = 16'h00FF;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    check_eq("ff_underrun", 32'(underrun), 32'd1);
    check_eq("ff_accepted", 32'(ready), 32'd0);
    repeat (2 * 256 + 20) @(negedge clk);

    check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
